// File: rtl/norm_div.sv
// Bilateral-filter normalisation: weighted pixel sum / weight sum, one quotient bit per clock,
// round-half-up and saturation to pixel range, tag carried alongside the result.
module norm_div #(
  parameter int NUM_W = 27,
  parameter int DEN_W = 20,
  parameter int Q_W   = 8,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] in_num,
  input  logic [DEN_W-1:0] in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   out_pix,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div0
);

  localparam int ITER  = NUM_W + 1;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state, state_nx;
  logic [NUM_W:0]   d2;
  logic [NUM_W:0]   q2;
  logic [DEN_W-1:0] den;
  logic [DEN_W:0]   rem;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_hold;

  logic             accept;
  logic [DEN_W:0]   rem_sh;
  logic             qbit;
  logic [DEN_W:0]   rem_nx;
  logic [NUM_W:0]   q2_nx;

  function automatic logic [NUM_W:0] round_half_up(input logic [NUM_W:0] q2v);
    logic [NUM_W+1:0] s;
    s = {1'b0, q2v} + {{(NUM_W+1){1'b0}}, 1'b1};
    return s[NUM_W+1:1];
  endfunction

  function automatic logic [Q_W-1:0] saturate(input logic [NUM_W:0] q);
    logic [NUM_W:0] lim;
    lim = {{(NUM_W+1-Q_W){1'b0}}, {Q_W{1'b1}}};
    if (q > lim) return {Q_W{1'b1}};
    else         return q[Q_W-1:0];
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Remainder stays below den, so its low DEN_W bits hold it and the shift never overflows.
  assign rem_sh = {rem[DEN_W-1:0], d2[NUM_W]};
  assign qbit   = (rem_sh >= {1'b0, den});
  assign rem_nx = qbit ? (rem_sh - {1'b0, den}) : rem_sh;
  assign q2_nx  = {q2[NUM_W-1:0], qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (in_den == '0) ? DONE : DIV;
      DIV:  if (cnt == '0) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d2       <= '0;
      q2       <= '0;
      den      <= '0;
      rem      <= '0;
      cnt      <= '0;
      tag_hold <= '0;
      out_pix  <= '0;
      out_tag  <= '0;
      out_div0 <= 1'b0;
    end else if (accept) begin
      tag_hold <= in_tag;
      if (in_den == '0) begin
        out_pix  <= '0;
        out_div0 <= 1'b1;
        out_tag  <= in_tag;
      end else begin
        d2  <= {in_num, 1'b0};
        den <= in_den;
        rem <= '0;
        q2  <= '0;
        cnt <= CNT_W'(ITER - 1);
      end
    end else if (state == DIV) begin
      d2  <= {d2[NUM_W-1:0], 1'b0};
      rem <= rem_nx;
      q2  <= q2_nx;
      cnt <= cnt - 1'b1;
      // Last iteration: result taken straight from the combinational quotient.
      if (cnt == '0) begin
        out_pix  <= saturate(round_half_up(q2_nx));
        out_div0 <= 1'b0;
        out_tag  <= tag_hold;
      end
    end
  end

endmodule

// File: tb/tb_norm_div.sv
// Directed and randomized checks of norm_div against a rounded-division reference model.
module tb_norm_div;

  localparam int NUM_W = 27;
  localparam int DEN_W = 20;
  localparam int Q_W   = 8;
  localparam int TAG_W = 8;
  localparam int LAT   = NUM_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NUM_W-1:0] in_num = '0;
  logic [DEN_W-1:0] in_den = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [Q_W-1:0]   out_pix;
  logic [TAG_W-1:0] out_tag;
  logic             out_div0;

  int errors = 0;
  int checks = 0;

  norm_div #(.NUM_W(NUM_W), .DEN_W(DEN_W), .Q_W(Q_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_den(in_den), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_tag(out_tag), .out_div0(out_div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Nearest integer to num/den, ties upward, clipped to pixel range.
  function automatic longint ref_pix(input longint num, input longint den);
    longint q;
    if (den == 0) return 0;
    q = (2 * num + den) / (2 * den);
    return (q > 255) ? 255 : q;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one job; leaves the bench one sample after out_valid rose (or after a timeout).
  task automatic issue(input longint num, input longint den, input int tag, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin tick(); guard++; end
    check("in_ready_before_issue", in_ready, 1);
    in_num = NUM_W'(num); in_den = DEN_W'(den); in_tag = TAG_W'(tag);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_num = '1; in_den = '1; in_tag = '1;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic run_job(input string name, input longint num, input longint den, input int tag);
    int lat;
    longint exp_pix;
    exp_pix = ref_pix(num, den);
    issue(num, den, tag, lat);
    check({name, "_latency"}, lat, (den == 0) ? 0 : LAT);
    check({name, "_pix"}, out_pix, exp_pix);
    check({name, "_tag"}, out_tag, tag);
    check({name, "_div0"}, out_div0, (den == 0) ? 1 : 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_release"}, {out_valid, in_ready, out_pix}, {1'b0, 1'b1, Q_W'(exp_pix)});
  endtask

  initial begin
    int lat;
    longint num, den;
    int mode;

    #2;
    check("reset_outputs", {out_valid, out_pix, out_tag, out_div0}, 0);
    check("reset_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_valid", out_valid, 0);

    run_job("t1", 1000, 10, 8'h11);
    run_job("t2a", 1005, 10, 8'h21);
    run_job("t2b", 1004, 10, 8'h22);
    run_job("t2c", 15, 10, 8'h23);
    run_job("t2d", 14, 10, 8'h24);
    run_job("t3a", 5000, 10, 8'h31);
    run_job("t3b", (1 << 27) - 1, 1, 8'h32);
    run_job("t3c", (1 << 27) - 1, (1 << 20) - 1, 8'h33);
    run_job("t4", 1234, 0, 8'h5A);
    run_job("zero_num", 0, 777, 8'h40);

    // Backpressure: result and tag must hold while downstream stalls.
    issue(2550, 10, 8'hB7, lat);
    check("bp_latency", lat, LAT);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {out_valid, in_ready, out_pix, out_tag}, {1'b1, 1'b0, 8'd255, 8'hB7});
      in_valid = 1'b1; in_den = 20'd0;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {out_valid, in_ready, out_pix, out_tag}, {1'b0, 1'b1, 8'd255, 8'hB7});

    // Reset part-way through a division.
    in_num = 27'd1000; in_den = 20'd10; in_tag = 8'hC3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {out_valid, out_pix, out_tag, out_div0}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midreset_in_ready", in_ready, 1);
    run_job("post_reset", 300, 3, 8'h07);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin den = $urandom_range(1, 4095); num = $urandom_range(0, 256 * den); end
        1: begin den = $urandom_range(1, (1 << 20) - 1); num = $urandom_range(0, (1 << 27) - 1); end
        2: begin den = 0; num = $urandom_range(0, (1 << 27) - 1); end
        3: begin den = $urandom_range(1, 40); num = $urandom_range(0, 255) * den + den / 2; end
        default: begin den = $urandom_range(1, 64); num = $urandom_range(0, 20000); end
      endcase
      run_job("rand", num, den, $urandom_range(0, 255));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
